// File: rtl/rs1513_enc_serial_if.sv
// Symbol stream bundle for the RS(15,13) serial encoder: the data input and the codeword output, each with a valid/ready handshake.
interface rs1513_enc_serial_if;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sop;
  logic       out_eop;

  // Upstream/downstream side: drives the data in and the output ready.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sop, out_eop
  );

  // Encoder side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sop, out_eop
  );
endinterface

// File: rtl/rs1513_enc_serial.sv
// Symbol-serial systematic RS(15,13) encoder over GF(16): 13 data symbols pass through, then parity P1, P0.
// Optional macro RS1513_ENC_ERR_INJ_EN adds err_inj, which flips bit 0 of the emitted P0.
module rs1513_enc_serial (
  input  logic clk,
  input  logic rst,
`ifdef RS1513_ENC_ERR_INJ_EN
  input  logic err_inj,
`endif
  rs1513_enc_serial_if.slave bus
);

  typedef enum logic [1:0] {DATA, PAR1, PAR0} state_t;

  // Multiply by alpha modulo x^4+x+1; the constant products g1=6 and g0=8 are built from it.
  function automatic logic [3:0] xtime(input logic [3:0] a);
    return {a[2], a[1], a[0] ^ a[3], a[3]};
  endfunction

  function automatic logic [3:0] mulG1(input logic [3:0] a);
    return xtime(a) ^ xtime(xtime(a));
  endfunction

  function automatic logic [3:0] mulG0(input logic [3:0] a);
    return xtime(xtime(xtime(a)));
  endfunction

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] r1_q, r1_d;
  logic [3:0] r0_q, r0_d;
  logic [3:0] outData_q, outData_d;
  logic       outValid_q, outValid_d;
  logic       outSop_q, outSop_d;
  logic       outEop_q, outEop_d;

  logic       slotFree;
  logic       inReady;
  logic [3:0] fb;
  logic       errBit;

`ifdef RS1513_ENC_ERR_INJ_EN
  assign errBit = err_inj;
`else
  assign errBit = 1'b0;
`endif

  assign bus.in_ready  = inReady;
  assign bus.out_data  = outData_q;
  assign bus.out_valid = outValid_q;
  assign bus.out_sop   = outSop_q;
  assign bus.out_eop   = outEop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DATA;
      cnt_q      <= 4'd0;
      r1_q       <= 4'd0;
      r0_q       <= 4'd0;
      outData_q  <= 4'd0;
      outValid_q <= 1'b0;
      outSop_q   <= 1'b0;
      outEop_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r1_q       <= r1_d;
      r0_q       <= r0_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      outSop_q   <= outSop_d;
      outEop_q   <= outEop_d;
    end
  end

  // A held output keeps its data/sop/eop; valid falls only when the symbol is consumed and nothing replaces it.
  always_comb begin
    slotFree   = !outValid_q || bus.out_ready;
    inReady    = (state_q == DATA) && slotFree;
    fb         = bus.in_data ^ r1_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    r1_d       = r1_q;
    r0_d       = r0_q;
    outData_d  = outData_q;
    outValid_d = outValid_q && !bus.out_ready;
    outSop_d   = outSop_q;
    outEop_d   = outEop_q;

    unique case (state_q)
      DATA: begin
        if (inReady && bus.in_valid) begin
          outData_d  = bus.in_data;
          outValid_d = 1'b1;
          outSop_d   = (cnt_q == 4'd0);
          outEop_d   = 1'b0;
          r1_d       = r0_q ^ mulG1(fb);
          r0_d       = mulG0(fb);
          if (cnt_q == 4'd12) begin
            state_d = PAR1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      PAR1: begin
        if (slotFree) begin
          outData_d  = r1_q;
          outValid_d = 1'b1;
          outSop_d   = 1'b0;
          outEop_d   = 1'b0;
          state_d    = PAR0;
        end
      end
      PAR0: begin
        if (slotFree) begin
          outData_d  = r0_q ^ {3'b000, errBit};
          outValid_d = 1'b1;
          outSop_d   = 1'b0;
          outEop_d   = 1'b1;
          r1_d       = 4'd0;
          r0_d       = 4'd0;
          cnt_d      = 4'd0;
          state_d    = DATA;
        end
      end
      default: state_d = DATA;
    endcase
  end

endmodule
